// File: rtl/ins_loader_pkg.sv
// Shared constants and state encoding for the boot-time instruction loader.
// The default geometry matches the datapath's instruction memory.
package ins_loader_pkg;

    localparam int DEF_ADDR_W     = 5;
    localparam int DEF_DEPTH      = 2 ** DEF_ADDR_W;
    localparam int BYTES_PER_WORD = 4;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_RUN
    } state_t;

endpackage

// File: rtl/ins_loader_byte_packer.sv
// Packs a byte stream MSB-first into 32-bit words; word_full strobes on the
// accept that completes a word.
module ins_loader_byte_packer
    import ins_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        accept,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    logic [IDX_W-1:0] idx_reg;
    logic [31:0]      shift_reg;
    logic [31:0]      shift_next;

    // Each lane takes the byte from the lane below; the newest byte enters at [7:0],
    // so after four accepts the first byte sits in [31:24].
    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            if (gi == 0) begin : g_low
                assign shift_next[7:0] = byte_in;
            end else begin : g_up
                assign shift_next[gi*8 +: 8] = shift_reg[(gi-1)*8 +: 8];
            end
        end
    endgenerate

    assign word      = shift_reg;
    assign word_full = accept && (idx_reg == IDX_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg   <= '0;
            shift_reg <= '0;
        end else begin
            if (clear) begin
                idx_reg <= '0;
            end else if (accept) begin
                idx_reg <= idx_reg + 1'b1;
            end
            if (accept) begin
                shift_reg <= shift_next;
            end
        end
    end

endmodule

// File: rtl/ins_loader.sv
// Boot loader: streams bytes into the instruction memory word by word, holding
// the CPU in reset until the requested number of words has been written.
module ins_loader
    import ins_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              InsWrEN,
    output logic [ADDR_W-1:0] InsWrAddr,
    output logic [31:0]       InsDataIn,
    output logic              cpu_nRST,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_t            state_reg, state_next;
    logic [ADDR_W:0]   count_reg, count_next;
    logic [ADDR_W:0]   written_reg, written_next;
    logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
    logic [ADDR_W:0]   start_count;
    logic              accept, clear, word_full;
    logic [31:0]       word;

    // The written counter is one bit wider than the address so a full-depth load
    // terminates without the address ever wrapping.
    assign start_count = (word_count > DEPTH_C) ? DEPTH_C : word_count;

    ins_loader_byte_packer u_packer (
        .clk       (clk),
        .rst       (RST),
        .accept    (accept),
        .clear     (clear),
        .byte_in   (byte_in),
        .word      (word),
        .word_full (word_full)
    );

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_reg   <= ST_IDLE;
            count_reg   <= '0;
            written_reg <= '0;
            wr_addr_reg <= '0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            written_reg <= written_next;
            wr_addr_reg <= wr_addr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        written_next = written_reg;
        wr_addr_next = wr_addr_reg;
        accept       = 1'b0;
        clear        = 1'b0;
        case (state_reg)
            ST_IDLE, ST_RUN: begin
                if (start) begin
                    count_next   = start_count;
                    written_next = '0;
                    clear        = 1'b1;
                    state_next   = (start_count == '0) ? ST_RUN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                accept = byte_valid;
                if (word_full) begin
                    wr_addr_next = written_reg[ADDR_W-1:0];
                    state_next   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                written_next = written_reg + 1'b1;
                clear        = 1'b1;
                state_next   = (written_next == count_reg) ? ST_RUN : ST_LOAD;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from registered state; the packer keeps the last word
    // visible on InsDataIn while running.
    assign byte_ready = (state_reg == ST_LOAD);
    assign InsWrEN    = (state_reg == ST_WRITE);
    assign InsWrAddr  = wr_addr_reg;
    assign InsDataIn  = word;
    assign cpu_nRST   = (state_reg == ST_RUN);
    assign done       = (state_reg == ST_RUN);
    assign busy       = (state_reg == ST_LOAD) || (state_reg == ST_WRITE);

endmodule
